// File: rtl/soc_arb_pkg.sv
// Shared types for the OBI memory-port arbiter: FSM states and requester IDs.
package soc_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    typedef logic arb_id_t;

    localparam arb_id_t ARB_ID_M0 = 1'b0;
    localparam arb_id_t ARB_ID_M1 = 1'b1;

endpackage

// File: rtl/obi_outstanding_fifo.sv
// In-order table of requester IDs for granted-but-unanswered OBI transfers.
module obi_outstanding_fifo
    import soc_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  arb_id_t          push_id_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output arb_id_t          head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    arb_id_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wr_ptr] <= push_id_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (pop_i) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign head_o  = r_mem[r_rd_ptr];

endmodule

// File: rtl/obi_mem_port_arbiter.sv
// Two-requester OBI arbiter sharing one memory port, with in-order response routing.
// Optional stall counters enabled by defining OBI_ARB_PERF_CNT_EN.
//
// state      | meaning
// ARB_IDLE   | winner picked combinationally each cycle (round-robin on conflict)
// ARB_LOCKED | request presented but not granted; mux held on r_owner until granted
module obi_mem_port_arbiter
    import soc_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [BE_WIDTH-1:0]   m0_be_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [BE_WIDTH-1:0]   m1_be_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  s_req_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic                  s_we_o,
    output logic [BE_WIDTH-1:0]   s_be_o,
    output logic [DATA_WIDTH-1:0] s_wdata_o,
    input  logic                  s_gnt_i,
    input  logic                  s_rvalid_i,
    input  logic [DATA_WIDTH-1:0] s_rdata_i,
    output logic                  rsp_err_o
`ifdef OBI_ARB_PERF_CNT_EN
    ,
    output logic [31:0]           perf_m0_stall_o,
    output logic [31:0]           perf_m1_stall_o
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    arb_id_t          r_owner;
    arb_id_t          w_owner_nxt;
    arb_id_t          r_rr_ptr;
    arb_id_t          w_rr_nxt;
    arb_id_t          w_sel;
    arb_id_t          w_head;
    logic             w_sel_req;
    logic             w_accept;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             r_rsp_err;

    always_comb begin
        w_sel       = r_rr_ptr;
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        s_addr_o    = '0;
        s_we_o      = 1'b0;
        s_be_o      = '0;
        s_wdata_o   = '0;

        if (r_state == ARB_LOCKED) begin
            w_sel = r_owner;
        end else if (m0_req_i && !m1_req_i) begin
            w_sel = ARB_ID_M0;
        end else if (m1_req_i && !m0_req_i) begin
            w_sel = ARB_ID_M1;
        end

        w_sel_req = (w_sel == ARB_ID_M1) ? m1_req_i : m0_req_i;
        // A full table blocks the request outright, even if a pop lands this cycle.
        s_req_o   = w_sel_req & ~w_full & ~rst_i;
        w_accept  = s_req_o & s_gnt_i;

        if (s_req_o) begin
            s_addr_o  = (w_sel == ARB_ID_M1) ? m1_addr_i  : m0_addr_i;
            s_we_o    = (w_sel == ARB_ID_M1) ? m1_we_i    : m0_we_i;
            s_be_o    = (w_sel == ARB_ID_M1) ? m1_be_i    : m0_be_i;
            s_wdata_o = (w_sel == ARB_ID_M1) ? m1_wdata_i : m0_wdata_i;
        end

        case (r_state)
            ARB_IDLE: begin
                if (s_req_o && s_gnt_i) begin
                    w_rr_nxt = ~w_sel;
                end else if (s_req_o) begin
                    w_state_nxt = ARB_LOCKED;
                    w_owner_nxt = w_sel;
                end
            end
            ARB_LOCKED: begin
                if (w_accept) begin
                    w_state_nxt = ARB_IDLE;
                    w_rr_nxt    = ~r_owner;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ARB_IDLE;
            r_owner  <= ARB_ID_M0;
            r_rr_ptr <= ARB_ID_M0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    obi_outstanding_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_outstanding (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (w_accept),
        .push_id_i (w_sel),
        .pop_i     (w_pop),
        .full_o    (w_full),
        .empty_o   (w_empty),
        .count_o   (w_count),
        .head_o    (w_head)
    );

    assign m0_gnt_o    = w_accept & (w_sel == ARB_ID_M0);
    assign m1_gnt_o    = w_accept & (w_sel == ARB_ID_M1);
    assign w_pop       = s_rvalid_i & ~w_empty & ~rst_i;
    assign m0_rvalid_o = w_pop & (w_head == ARB_ID_M0);
    assign m1_rvalid_o = w_pop & (w_head == ARB_ID_M1);
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_err <= 1'b0;
        end else if (s_rvalid_i && w_empty) begin
            r_rsp_err <= 1'b1;
        end
    end

    assign rsp_err_o = r_rsp_err;

`ifdef OBI_ARB_PERF_CNT_EN
    logic [31:0] r_perf_m0_stall;
    logic [31:0] r_perf_m1_stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_m0_stall <= '0;
            r_perf_m1_stall <= '0;
        end else begin
            if (m0_req_i && !m0_gnt_o && !(&r_perf_m0_stall)) begin
                r_perf_m0_stall <= r_perf_m0_stall + 32'd1;
            end
            if (m1_req_i && !m1_gnt_o && !(&r_perf_m1_stall)) begin
                r_perf_m1_stall <= r_perf_m1_stall + 32'd1;
            end
        end
    end

    assign perf_m0_stall_o = r_perf_m0_stall;
    assign perf_m1_stall_o = r_perf_m1_stall;
`endif

endmodule

// File: tb/tb_obi_mem_port_arbiter.sv
// Directed self-checking bench for obi_mem_port_arbiter (default build, MAX_OUTSTANDING = 2).
module tb_obi_mem_port_arbiter;
    import soc_arb_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_we_o, s_gnt_i, s_rvalid_i, rsp_err_o;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
    logic [3:0]  s_be_o;
`ifdef OBI_ARB_PERF_CNT_EN
    logic [31:0] perf_m0_stall_o, perf_m1_stall_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    obi_mem_port_arbiter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .m0_req_i    (m0_req_i),
        .m0_addr_i   (m0_addr_i),
        .m0_we_i     (m0_we_i),
        .m0_be_i     (m0_be_i),
        .m0_wdata_i  (m0_wdata_i),
        .m0_gnt_o    (m0_gnt_o),
        .m0_rvalid_o (m0_rvalid_o),
        .m0_rdata_o  (m0_rdata_o),
        .m1_req_i    (m1_req_i),
        .m1_addr_i   (m1_addr_i),
        .m1_we_i     (m1_we_i),
        .m1_be_i     (m1_be_i),
        .m1_wdata_i  (m1_wdata_i),
        .m1_gnt_o    (m1_gnt_o),
        .m1_rvalid_o (m1_rvalid_o),
        .m1_rdata_o  (m1_rdata_o),
        .s_req_o     (s_req_o),
        .s_addr_o    (s_addr_o),
        .s_we_o      (s_we_o),
        .s_be_o      (s_be_o),
        .s_wdata_o   (s_wdata_o),
        .s_gnt_i     (s_gnt_i),
        .s_rvalid_i  (s_rvalid_i),
        .s_rdata_i   (s_rdata_i),
        .rsp_err_o   (rsp_err_o)
`ifdef OBI_ARB_PERF_CNT_EN
        ,
        .perf_m0_stall_o (perf_m0_stall_o),
        .perf_m1_stall_o (perf_m1_stall_o)
`endif
    );

    // Inputs change 1 ns after the rising edge; outputs are sampled 4 ns later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic idle_inputs();
        m0_req_i = 0; m0_addr_i = 32'h0; m0_we_i = 0; m0_be_i = 4'h0; m0_wdata_i = 32'h0;
        m1_req_i = 0; m1_addr_i = 32'h0; m1_we_i = 0; m1_be_i = 4'h0; m1_wdata_i = 32'h0;
        s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1;
        step();
        step();
        rst_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1;
        m0_req_i = 1; m0_addr_i = 32'h44; s_gnt_i = 1;
        step();
        settle();
        n_cmp++;
        if (s_req_o !== 1'b0 || m0_gnt_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_req_gated: s_req=%b m0_gnt=%b required 0/0", s_req_o, m0_gnt_o);
        end
        step();
        idle_inputs();
        rst_i = 0;
        settle();
        n_cmp++;
        if ({s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, rsp_err_o} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required 000000",
                     {s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, rsp_err_o});
        end
        n_cmp++;
        if (dut.r_state !== ARB_IDLE || dut.w_count !== 2'd0 || dut.r_rr_ptr !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: state=%b count=%0d rr=%b required 0/0/0",
                     dut.r_state, dut.w_count, dut.r_rr_ptr);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        m0_req_i = 1; m0_addr_i = 32'h0000_0010; m0_be_i = 4'hF; s_gnt_i = 1;
        settle();
        n_cmp++;
        if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0 || s_req_o !== 1'b1 || s_addr_o !== 32'h10
            || s_be_o !== 4'hF) begin
            n_err++;
            $display("FAIL single_grant: m0_gnt=%b m1_gnt=%b s_req=%b addr=%h be=%h required 1/0/1/00000010/f",
                     m0_gnt_o, m1_gnt_o, s_req_o, s_addr_o, s_be_o);
        end
        step();
        idle_inputs();
        s_rvalid_i = 1; s_rdata_i = 32'hDEAD_BEEF;
        settle();
        n_cmp++;
        if (m0_rvalid_o !== 1'b1 || m1_rvalid_o !== 1'b0 || m0_rdata_o !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL single_rsp: m0_rvalid=%b m1_rvalid=%b rdata=%h required 1/0/deadbeef",
                     m0_rvalid_o, m1_rvalid_o, m0_rdata_o);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_alternate();
        logic        exp_gnt_id;
        logic [31:0] exp_addr;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            m0_req_i = 1; m0_addr_i = 32'h100; m0_we_i = 1; m0_wdata_i = 32'hA0A0_0000;
            m1_req_i = 1; m1_addr_i = 32'h200; m1_we_i = 0; m1_wdata_i = 32'hB1B1_1111;
            s_gnt_i = 1; s_rvalid_i = (k > 0); s_rdata_i = 32'h1000 + k;
            exp_gnt_id = k[0];
            exp_addr   = exp_gnt_id ? 32'h200 : 32'h100;
            settle();
            n_cmp++;
            if (m0_gnt_o !== ~exp_gnt_id || m1_gnt_o !== exp_gnt_id || s_addr_o !== exp_addr
                || s_we_o !== ~exp_gnt_id) begin
                n_err++;
                $display("FAIL alt_grant[%0d]: m0_gnt=%b m1_gnt=%b addr=%h we=%b required m1_gnt=%b addr=%h",
                         k, m0_gnt_o, m1_gnt_o, s_addr_o, s_we_o, exp_gnt_id, exp_addr);
            end
            if (k > 0) begin
                n_cmp++;
                if (m0_rvalid_o !== exp_gnt_id || m1_rvalid_o !== ~exp_gnt_id) begin
                    n_err++;
                    $display("FAIL alt_rsp[%0d]: m0_rvalid=%b m1_rvalid=%b required %b/%b",
                             k, m0_rvalid_o, m1_rvalid_o, exp_gnt_id, ~exp_gnt_id);
                end
            end
            step();
        end
        idle_inputs();
        s_rvalid_i = 1;
        settle();
        n_cmp++;
        if (m1_rvalid_o !== 1'b1 || m0_rvalid_o !== 1'b0) begin
            n_err++;
            $display("FAIL alt_drain: m0_rvalid=%b m1_rvalid=%b required 0/1", m0_rvalid_o, m1_rvalid_o);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_locked();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            m1_req_i = 1; m1_addr_i = 32'h300;
            m0_req_i = (k >= 1); m0_addr_i = 32'h100;
            s_gnt_i  = (k == 3);
            settle();
            n_cmp++;
            if (s_addr_o !== 32'h300 || s_req_o !== 1'b1 || m0_gnt_o !== 1'b0 || m1_gnt_o !== (k == 3)) begin
                n_err++;
                $display("FAIL lock_hold[%0d]: addr=%h s_req=%b m0_gnt=%b m1_gnt=%b required 00000300/1/0/%b",
                         k, s_addr_o, s_req_o, m0_gnt_o, m1_gnt_o, (k == 3));
            end
            step();
        end
        m1_req_i = 0; m0_req_i = 1; s_gnt_i = 1;
        settle();
        n_cmp++;
        if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0 || s_addr_o !== 32'h100) begin
            n_err++;
            $display("FAIL lock_next: m0_gnt=%b m1_gnt=%b addr=%h required 1/0/00000100",
                     m0_gnt_o, m1_gnt_o, s_addr_o);
        end
        step();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            s_rvalid_i = 1;
            settle();
            n_cmp++;
            if (m1_rvalid_o !== (k == 0) || m0_rvalid_o !== (k == 1)) begin
                n_err++;
                $display("FAIL lock_order[%0d]: m0_rvalid=%b m1_rvalid=%b required %b/%b",
                         k, m0_rvalid_o, m1_rvalid_o, (k == 1), (k == 0));
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_full();
        do_reset();
        m0_req_i = 1; m0_addr_i = 32'h400; s_gnt_i = 1;
        step();
        m0_req_i = 0; m1_req_i = 1; m1_addr_i = 32'h500;
        settle();
        n_cmp++;
        if (m1_gnt_o !== 1'b1) begin
            n_err++;
            $display("FAIL full_second: m1_gnt=%b required 1", m1_gnt_o);
        end
        step();
        m1_req_i = 0; m0_req_i = 1; m0_addr_i = 32'h600;
        for (int k = 0; k < 3; k++) begin
            s_rvalid_i = (k == 2);
            settle();
            n_cmp++;
            if (s_req_o !== 1'b0 || m0_gnt_o !== 1'b0 || m0_rvalid_o !== (k == 2) || m1_rvalid_o !== 1'b0) begin
                n_err++;
                $display("FAIL full_block[%0d]: s_req=%b m0_gnt=%b m0_rvalid=%b m1_rvalid=%b required 0/0/%b/0",
                         k, s_req_o, m0_gnt_o, m0_rvalid_o, m1_rvalid_o, (k == 2));
            end
            step();
        end
        s_rvalid_i = 0;
        settle();
        n_cmp++;
        if (s_req_o !== 1'b1 || m0_gnt_o !== 1'b1 || s_addr_o !== 32'h600) begin
            n_err++;
            $display("FAIL full_release: s_req=%b m0_gnt=%b addr=%h required 1/1/00000600",
                     s_req_o, m0_gnt_o, s_addr_o);
        end
        step();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            s_rvalid_i = 1;
            settle();
            n_cmp++;
            if (m1_rvalid_o !== (k == 0) || m0_rvalid_o !== (k == 1)) begin
                n_err++;
                $display("FAIL full_order[%0d]: m0_rvalid=%b m1_rvalid=%b required %b/%b",
                         k, m0_rvalid_o, m1_rvalid_o, (k == 1), (k == 0));
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_rsp_err();
        do_reset();
        s_rvalid_i = 1; s_rdata_i = 32'h1234_5678;
        settle();
        n_cmp++;
        if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0 || rsp_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL err_no_rvalid: m0_rvalid=%b m1_rvalid=%b err=%b required 0/0/0",
                     m0_rvalid_o, m1_rvalid_o, rsp_err_o);
        end
        step();
        s_rvalid_i = 0;
        settle();
        n_cmp++;
        if (rsp_err_o !== 1'b1) begin
            n_err++;
            $display("FAIL err_set: err=%b required 1", rsp_err_o);
        end
        step();
        step();
        settle();
        n_cmp++;
        if (rsp_err_o !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky: err=%b required 1", rsp_err_o);
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_req_i = 1; m0_addr_i = 32'h700; s_gnt_i = 1;
        step();
        m0_req_i = 0; m1_req_i = 1; m1_addr_i = 32'h800; s_gnt_i = 0;
        step();
        n_cmp++;
        if (dut.r_state !== ARB_LOCKED || dut.w_count !== 2'd1) begin
            n_err++;
            $display("FAIL mid_precond: state=%b count=%0d required 1/1", dut.r_state, dut.w_count);
        end
        rst_i = 1;
        step();
        rst_i = 0;
        settle();
        n_cmp++;
        if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o} !== 4'b0 || dut.r_state !== ARB_IDLE
            || dut.w_count !== 2'd0) begin
            n_err++;
            $display("FAIL mid_reset: gnt/rvalid=%b state=%b count=%0d required 0000/0/0",
                     {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o}, dut.r_state, dut.w_count);
        end
        step();
        m1_req_i = 0; s_rvalid_i = 1;
        settle();
        n_cmp++;
        if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_stale_rsp: m0_rvalid=%b m1_rvalid=%b required 0/0", m0_rvalid_o, m1_rvalid_o);
        end
        step();
        s_rvalid_i = 0;
        settle();
        n_cmp++;
        if (rsp_err_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_err: err=%b required 1", rsp_err_o);
        end
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_i = 1;
        test_reset();
        test_single_read();
        test_alternate();
        test_locked();
        test_full();
        test_rsp_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
